mem_line_responder: RTL
=======================

# mem_line_responder

Main-memory responder for the cache refill/evict traffic. It serves 64 B cache-line reads as four 128-bit beats after a programmable latency, and it absorbs four-beat line write-backs into a 4096 x 128-bit array. It sits below the icache/dcache arbiter as the memory end of the `MEM_DATA_BUS`-wide interface and replaces the flat testbench memory.

## Interface
- `RD_LATENCY`, default 1: cycles from read-request handshake to first response beat; legal range 1..15.
- `MEM_INIT_FILE`, default "": hex image loaded with `$readmemh` at time 0 when non-empty.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert and active-low; deassertion is synchronous to `clk` externally.
- `req_r`  rv_if.RX  DW=`MEM_ADDR_BUS` (12)  line read request; data is the 128-bit-unit address, and `[1:0]` is ignored (treated as 0).
- `req_w`  rv_if_da.RX  AW=`MEM_ADDR_BUS`, DW=`MEM_DATA_BUS`  write-back beat; each beat carries its own address.
- `rsp_r`  rv_if.TX  DW=`MEM_DATA_BUS` (128)  read data beats, in order 0..3.

## Operation
- Storage is a `MEM_SIZE_Q` (4096) x 128 array. It is not cleared by reset. The full 12-bit address space is valid, so there is no range check.
- FSM states:
  - IDLE: `req_w.ready`=1. `req_r.ready`=!`req_w.valid`.
    - If `req_w.valid`, the beat is written and the FSM goes to WR_BURST with beat count 1. Write has priority over read so an evict completes before its refill.
    - Else if `req_r.valid`, the FSM latches the line address `{addr[11:2],2'b00}`, loads the latency counter with `RD_LATENCY-1`, and goes to RD_WAIT.
  - RD_WAIT: both readies are 0. The counter decrements each cycle. At 0 the FSM goes to RD_BURST with beat index 0.
  - RD_BURST: `rsp_r.valid`=1 and `rsp_r.data`=mem[line+beat].
    - On handshake, beat increments.
    - A handshake on beat 3 returns the FSM to IDLE.
    - Both readies are 0 in this state.
  - WR_BURST: `req_w.ready`=1 and `req_r.ready`=0. Each handshake writes mem[addr]<=wdata and increments the beat count. The handshake on the 4th beat returns the FSM to IDLE.
- The beat counter is 2 bits and the latency counter is 4 bits. The beat index wraps 3->0 only on burst exit.
- Read data is taken from the array at beat time, so a read after a completed write to the same line returns the new data.

## Timing
- Reset (`rst_n`=0, any time): state=IDLE, `rsp_r.valid`=0, `req_r.ready`=0, `req_w.ready`=0, counters=0.
  - Readies rise in the first cycle after deassertion.
  - A read or write in flight is aborted. Beats already written remain in the array; the rest are not written.
  - Array contents are untouched.
- Read: handshake at cycle T. First `rsp_r.valid` appears at T+`RD_LATENCY`+1 (registered output). With no backpressure, beats arrive on 4 consecutive cycles.
- Backpressure: while `rsp_r.valid`=1 and `rsp_r.ready`=0, `rsp_r.data` and the beat index are held. There are no bubbles between beats when ready stays high.
- The last read beat is handshaked at T'. The FSM is in IDLE at T'+1, with `req_r.ready` asserted that cycle.
- Write: a 4-beat burst with `req_w.valid` held high takes 4 cycles. The 4th handshake at T gives IDLE at T+1, and `req_w.ready` stays 1 so back-to-back bursts have no gap. Gaps in `req_w.valid` inside a burst are tolerated.
- Simultaneous `req_r.valid` and `req_w.valid` in IDLE: the write is accepted and the read waits with ready=0. The read is accepted in the IDLE cycle after the write burst, provided `req_w.valid` is low then.

## Test plan
- **Reset defaults.** Drive `rst_n` low mid-simulation, then check that all outputs are 0. After release, check `req_r.ready`=1 and `req_w.ready`=1 one cycle later.
- **Basic read, `RD_LATENCY`=1.** Preload mem[0x010..0x013]=A0..A3. Request addr 0x012 at T. Check beats A0,A1,A2,A3 at T+2..T+5, then `req_r.ready`=1 at T+6.
- **Write then read.** Write beats 0x7F0..0x7F3 with data D0..D3 back-to-back. Immediately request 0x7F0. Check that D0..D3 are returned.
- **Backpressure.** During a read, hold `rsp_r.ready`=0 for 3 cycles on beat 1. Check that data stays at A1, that no beat is skipped or duplicated, and that exactly 4 handshakes occur.
- **Simultaneous requests.** Assert read 0x020 and write 0x040 in the same IDLE cycle. Check the write is accepted first, `req_r.ready` is 0 until the write burst completes, and the read is then served correctly.
- **Reset mid-operation.**
  - Reset after 2 write beats to 0x100: mem[0x100..0x101] are updated and mem[0x102..0x103] are unchanged.
  - Reset during RD_BURST: `rsp_r.valid` drops asynchronously, and a new read afterwards behaves normally.

Source files
------------

// File: rtl/mem_line_responder.sv
// mem_line_responder: main-memory responder serving 4-beat line reads and absorbing 4-beat line write-backs
module mem_line_responder #(
  parameter int    RD_LATENCY    = 1,
  parameter string MEM_INIT_FILE = ""
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_r_valid,
  output logic         req_r_ready,
  input  logic [11:0]  req_r_data,
  input  logic         req_w_valid,
  output logic         req_w_ready,
  input  logic [11:0]  req_w_addr,
  input  logic [127:0] req_w_data,
  output logic         rsp_r_valid,
  input  logic         rsp_r_ready,
  output logic [127:0] rsp_r_data
);
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RD_WAIT  = 2'd1;
  localparam logic [1:0] RD_BURST = 2'd2;
  localparam logic [1:0] WR_BURST = 2'd3;

  logic [127:0] mem [4096];
  logic [1:0]   state;
  logic [1:0]   beat;
  logic [3:0]   lat;
  logic [9:0]   line;
  logic         rdy_en;
  logic         w_hs, r_hs, rsp_hs;
  logic         unused_bits;

  assign req_w_ready = rdy_en & (state == IDLE | state == WR_BURST);
  assign req_r_ready = rdy_en & (state == IDLE) & ~req_w_valid;
  assign rsp_r_valid = state == RD_BURST;
  assign rsp_r_data  = mem[{line, beat}];
  assign w_hs        = req_w_valid & req_w_ready;
  assign r_hs        = req_r_valid & req_r_ready;
  assign rsp_hs      = rsp_r_valid & rsp_r_ready;
  assign unused_bits = ^req_r_data[1:0];

  always_ff @(posedge clk)
    if (w_hs) mem[req_w_addr] <= req_w_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      beat   <= 2'd0;
      lat    <= 4'd0;
      line   <= 10'd0;
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      case (state)
        IDLE:
          if (w_hs) begin
            state <= WR_BURST;
            beat  <= 2'd1;
          end else if (r_hs) begin
            line  <= req_r_data[11:2];
            lat   <= 4'(RD_LATENCY - 1);
            state <= RD_WAIT;
          end
        RD_WAIT:
          if (lat == 4'd0) begin
            state <= RD_BURST;
            beat  <= 2'd0;
          end else lat <= lat - 4'd1;
        RD_BURST:
          if (rsp_hs) begin
            beat <= beat + 2'd1;
            if (beat == 2'd3) state <= IDLE;
          end
        WR_BURST:
          if (w_hs) begin
            beat <= beat + 2'd1;
            if (beat == 2'd3) state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
